// File: rtl/axi_arb_seq.sv
// rtl/axi_arb_seq.sv - sequential IF/MEM read arbiter with a separate MEM write channel
// Round-robin read arbitration between IF and MEM when ARB_RR_EN is defined, else IF has priority.
module axi_arb_seq #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_read_addr_i,
  input  logic              if_raddr_valid_i,
  input  logic [7:0]        if_rmask_i,
  input  logic [3:0]        if_rsize_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_rdata_ready_o,
  input  logic [ADDR_W-1:0] mem_read_addr_i,
  input  logic              mem_raddr_valid_i,
  input  logic [7:0]        mem_rmask_i,
  input  logic [3:0]        mem_rsize_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rdata_ready_o,
  input  logic [ADDR_W-1:0] mem_write_addr_i,
  input  logic              mem_write_valid_i,
  input  logic [7:0]        mem_wmask_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [3:0]        mem_wsize_i,
  output logic              mem_wdata_ready_o,
  output logic [ADDR_W-1:0] arb_read_addr_o,
  output logic [7:0]        arb_rmask_o,
  output logic [3:0]        arb_rsize_o,
  output logic              arb_raddr_valid_o,
  input  logic [DATA_W-1:0] arb_rdata_i,
  input  logic              arb_rdata_ready_i,
  output logic [ADDR_W-1:0] arb_write_addr_o,
  output logic [7:0]        arb_wmask_o,
  output logic [DATA_W-1:0] arb_wdata_o,
  output logic [3:0]        arb_wsize_o,
  output logic              arb_write_valid_o,
  input  logic              arb_wdata_ready_i
);

  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  owner_t            owner, grant;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_eligible;

`ifdef ARB_RR_EN
  logic rr_mem;
`endif

  // A MEM read must not overtake a MEM write that is pending or in flight
  assign mem_eligible = mem_raddr_valid_i && (w_state == W_IDLE) && !mem_write_valid_i;

  always_comb begin
    grant = OWN_NONE;
`ifdef ARB_RR_EN
    if (if_raddr_valid_i && mem_eligible) grant = rr_mem ? OWN_MEM : OWN_IF;
    else if (if_raddr_valid_i)            grant = OWN_IF;
    else if (mem_eligible)                grant = OWN_MEM;
`else
    if (if_raddr_valid_i)  grant = OWN_IF;
    else if (mem_eligible) grant = OWN_MEM;
`endif
  end

  always_comb begin
    r_next            = r_state;
    arb_raddr_valid_o = 1'b0;
    if_rdata_ready_o  = 1'b0;
    mem_rdata_ready_o = 1'b0;
    if_rdata_o        = '0;
    mem_rdata_o       = '0;
    case (r_state)
      R_IDLE: if (grant != OWN_NONE) r_next = R_BUSY;
      R_BUSY: begin
        arb_raddr_valid_o = 1'b1;
        if (arb_rdata_ready_i) r_next = R_RESP;
      end
      R_RESP: begin
        r_next = R_IDLE;
        if (owner == OWN_IF) begin
          if_rdata_ready_o = 1'b1;
          if_rdata_o       = rdata_q;
        end else if (owner == OWN_MEM) begin
          mem_rdata_ready_o = 1'b1;
          mem_rdata_o       = rdata_q;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next            = w_state;
    arb_write_valid_o = 1'b0;
    mem_wdata_ready_o = 1'b0;
    case (w_state)
      W_IDLE: if (mem_write_valid_i) w_next = W_BUSY;
      W_BUSY: begin
        arb_write_valid_o = 1'b1;
        if (arb_wdata_ready_i) w_next = W_RESP;
      end
      W_RESP: begin
        mem_wdata_ready_o = 1'b1;
        w_next            = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= R_IDLE;
      w_state          <= W_IDLE;
      owner            <= OWN_NONE;
      rdata_q          <= '0;
      arb_read_addr_o  <= '0;
      arb_rmask_o      <= '0;
      arb_rsize_o      <= '0;
      arb_write_addr_o <= '0;
      arb_wmask_o      <= '0;
      arb_wdata_o      <= '0;
      arb_wsize_o      <= '0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_state == R_IDLE && grant != OWN_NONE) begin
        owner <= grant;
        if (grant == OWN_IF) begin
          arb_read_addr_o <= if_read_addr_i;
          arb_rmask_o     <= if_rmask_i;
          arb_rsize_o     <= if_rsize_i;
        end else begin
          arb_read_addr_o <= mem_read_addr_i;
          arb_rmask_o     <= mem_rmask_i;
          arb_rsize_o     <= mem_rsize_i;
        end
      end
      if (r_state == R_BUSY && arb_rdata_ready_i) rdata_q <= arb_rdata_i;
      if (w_state == W_IDLE && mem_write_valid_i) begin
        arb_write_addr_o <= mem_write_addr_i;
        arb_wmask_o      <= mem_wmask_i;
        arb_wdata_o      <= mem_wdata_i;
        arb_wsize_o      <= mem_wsize_i;
      end
    end
  end

`ifdef ARB_RR_EN
  // Pointer moves to the side that did not just get served
  always_ff @(posedge clk) begin
    if (rst) rr_mem <= 1'b0;
    else if (r_state == R_RESP) rr_mem <= (owner == OWN_IF);
  end
`endif

endmodule

// File: tb/tb_axi_arb_seq.sv
// tb/tb_axi_arb_seq.sv - self-checking bench for axi_arb_seq: vector table, directed corners, random traffic vs model
module tb_axi_arb_seq;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_read_addr_i, mem_read_addr_i, mem_write_addr_i, mem_wdata_i, arb_rdata_i;
  logic        if_raddr_valid_i, mem_raddr_valid_i, mem_write_valid_i;
  logic [7:0]  if_rmask_i, mem_rmask_i, mem_wmask_i;
  logic [3:0]  if_rsize_i, mem_rsize_i, mem_wsize_i;
  logic        arb_rdata_ready_i, arb_wdata_ready_i;
  logic [63:0] if_rdata_o, mem_rdata_o, arb_read_addr_o, arb_write_addr_o, arb_wdata_o;
  logic        if_rdata_ready_o, mem_rdata_ready_o, mem_wdata_ready_o;
  logic        arb_raddr_valid_o, arb_write_valid_o;
  logic [7:0]  arb_rmask_o, arb_wmask_o;
  logic [3:0]  arb_rsize_o, arb_wsize_o;

  always #5 clk = ~clk;

  axi_arb_seq #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .if_read_addr_i(if_read_addr_i), .if_raddr_valid_i(if_raddr_valid_i),
    .if_rmask_i(if_rmask_i), .if_rsize_i(if_rsize_i),
    .if_rdata_o(if_rdata_o), .if_rdata_ready_o(if_rdata_ready_o),
    .mem_read_addr_i(mem_read_addr_i), .mem_raddr_valid_i(mem_raddr_valid_i),
    .mem_rmask_i(mem_rmask_i), .mem_rsize_i(mem_rsize_i),
    .mem_rdata_o(mem_rdata_o), .mem_rdata_ready_o(mem_rdata_ready_o),
    .mem_write_addr_i(mem_write_addr_i), .mem_write_valid_i(mem_write_valid_i),
    .mem_wmask_i(mem_wmask_i), .mem_wdata_i(mem_wdata_i), .mem_wsize_i(mem_wsize_i),
    .mem_wdata_ready_o(mem_wdata_ready_o),
    .arb_read_addr_o(arb_read_addr_o), .arb_rmask_o(arb_rmask_o), .arb_rsize_o(arb_rsize_o),
    .arb_raddr_valid_o(arb_raddr_valid_o),
    .arb_rdata_i(arb_rdata_i), .arb_rdata_ready_i(arb_rdata_ready_i),
    .arb_write_addr_o(arb_write_addr_o), .arb_wmask_o(arb_wmask_o),
    .arb_wdata_o(arb_wdata_o), .arb_wsize_o(arb_wsize_o),
    .arb_write_valid_o(arb_write_valid_o), .arb_wdata_ready_i(arb_wdata_ready_i)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [3:0]  size;
    logic [63:0] data;
  } req_t;

  typedef struct {
    bit          if_v, mr_v, mw_v;
    bit          exp_rv;
    logic [63:0] exp_addr;
    bit          exp_wv;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t if_q[$], mr_q[$], mw_q[$];
  req_t if_cur, mr_cur, mw_cur, s_if, s_mr, s_mw;
  bit   if_pend, mr_pend, mw_pend;
  bit   s_if_v, s_mr_v, s_mw_v, s_mw_blk;
  bit   r_prev, w_prev, ptr_mem, both_seen;
  int   r_cnt, w_cnt, r_lat, w_lat, r_lat_fix, w_lat_fix;
  int   if_done, mr_done, mw_done, wack_cyc, mrise_cyc;
  int   gq[$];

  localparam logic [63:0] A_IF  = 64'h8000_0000;
  localparam logic [63:0] A_MEM = 64'h8000_1000;
  localparam logic [63:0] A_WR  = 64'h8000_2000;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Downstream memory: read data is a fixed scramble of the address
  function automatic logic [63:0] rd_model(logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic req_t mk(logic [63:0] a, logic [7:0] m, logic [3:0] s, logic [63:0] d);
    req_t r;
    r.addr = a; r.mask = m; r.size = s; r.data = d;
    return r;
  endfunction

  function automatic req_t mk_rand(int kind);
    req_t r;
    r.addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fff8)};
    if (kind != 0) r.addr[40] = 1'b1;
    r.mask = 8'($urandom);
    r.size = 4'($urandom_range(0, 3));
    r.data = {$urandom, $urandom};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    {if_read_addr_i, if_raddr_valid_i, if_rmask_i, if_rsize_i} = '0;
    {mem_read_addr_i, mem_raddr_valid_i, mem_rmask_i, mem_rsize_i} = '0;
    {mem_write_addr_i, mem_write_valid_i, mem_wmask_i, mem_wdata_i, mem_wsize_i} = '0;
    {arb_rdata_i, arb_rdata_ready_i, arb_wdata_ready_i} = '0;
  endtask

  task automatic model_clear();
    if_q.delete(); mr_q.delete(); mw_q.delete(); gq.delete();
    {if_pend, mr_pend, mw_pend, s_if_v, s_mr_v, s_mw_v, s_mw_blk} = '0;
    {r_prev, w_prev, ptr_mem, both_seen} = '0;
    r_cnt = 0; w_cnt = 0; r_lat = 0; w_lat = 0; r_lat_fix = -1; w_lat_fix = -1;
    if_done = 0; mr_done = 0; mw_done = 0; wack_cyc = -1; mrise_cyc = -1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    model_clear();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One cycle of requesters + downstream slaves, checking the DUT against the arbitration rules
  task automatic service();
    int exp_own, own_obs;
    bit ife, me, wack;
    wack = 1'b0;
    if (arb_raddr_valid_o && !r_prev) begin
      ife = s_if_v;
      me  = s_mr_v && !s_mw_blk;
      exp_own = -1;
      if (ife && me)  exp_own = (RR && ptr_mem) ? 1 : 0;
      else if (ife)   exp_own = 0;
      else if (me)    exp_own = 1;
      if (s_if_v && arb_read_addr_o == s_if.addr)      own_obs = 0;
      else if (s_mr_v && arb_read_addr_o == s_mr.addr) own_obs = 1;
      else                                             own_obs = 2;
      chk("grant_owner", own_obs, exp_own);
      if (exp_own == 0) begin
        chk("rd_mask", arb_rmask_o, s_if.mask);
        chk("rd_size", arb_rsize_o, s_if.size);
      end else if (exp_own == 1) begin
        chk("rd_mask", arb_rmask_o, s_mr.mask);
        chk("rd_size", arb_rsize_o, s_mr.size);
      end
      if (own_obs == 1) mrise_cyc = cyc;
      gq.push_back(own_obs);
      r_cnt = 0;
      r_lat = (r_lat_fix >= 0) ? r_lat_fix : int'($urandom_range(0, 3));
    end
    if (arb_raddr_valid_o && arb_write_valid_o) both_seen = 1'b1;
    arb_rdata_ready_i = arb_raddr_valid_o && (r_cnt >= r_lat);
    arb_rdata_i       = arb_raddr_valid_o ? rd_model(arb_read_addr_o) : 64'h0;
    if (arb_raddr_valid_o) r_cnt++;

    if (arb_write_valid_o && !w_prev) begin
      chk("wr_req_pending", s_mw_v, 1'b1);
      chk("wr_addr", arb_write_addr_o, s_mw.addr);
      chk("wr_data", arb_wdata_o, s_mw.data);
      chk("wr_mask", arb_wmask_o, s_mw.mask);
      chk("wr_size", arb_wsize_o, s_mw.size);
      w_cnt = 0;
      w_lat = (w_lat_fix >= 0) ? w_lat_fix : int'($urandom_range(0, 3));
    end
    arb_wdata_ready_i = arb_write_valid_o && (w_cnt >= w_lat);
    if (arb_write_valid_o) w_cnt++;

    if (if_rdata_ready_o) begin
      chk("if_ready_expected", if_pend, 1'b1);
      chk("if_rdata", if_rdata_o, rd_model(if_cur.addr));
      chk("if_resp_mem_quiet", mem_rdata_ready_o, 1'b0);
      if_pend = 1'b0; if_done++; ptr_mem = 1'b1;
    end
    if (mem_rdata_ready_o) begin
      chk("mem_ready_expected", mr_pend, 1'b1);
      chk("mem_rdata", mem_rdata_o, rd_model(mr_cur.addr));
      chk("mem_resp_if_data", if_rdata_o, 64'h0);
      mr_pend = 1'b0; mr_done++; ptr_mem = 1'b0;
    end
    if (mem_wdata_ready_o) begin
      chk("wr_ready_expected", mw_pend, 1'b1);
      mw_pend = 1'b0; mw_done++; wack = 1'b1; wack_cyc = cyc;
    end

    if (!if_pend && if_q.size() > 0) begin if_cur = if_q.pop_front(); if_pend = 1'b1; end
    if (!mr_pend && mr_q.size() > 0) begin mr_cur = mr_q.pop_front(); mr_pend = 1'b1; end
    if (!mw_pend && mw_q.size() > 0) begin mw_cur = mw_q.pop_front(); mw_pend = 1'b1; end

    if_raddr_valid_i  = if_pend;
    if_read_addr_i    = if_pend ? if_cur.addr : 64'h0;
    if_rmask_i        = if_pend ? if_cur.mask : 8'h0;
    if_rsize_i        = if_pend ? if_cur.size : 4'h0;
    mem_raddr_valid_i = mr_pend;
    mem_read_addr_i   = mr_pend ? mr_cur.addr : 64'h0;
    mem_rmask_i       = mr_pend ? mr_cur.mask : 8'h0;
    mem_rsize_i       = mr_pend ? mr_cur.size : 4'h0;
    mem_write_valid_i = mw_pend;
    mem_write_addr_i  = mw_pend ? mw_cur.addr : 64'h0;
    mem_wmask_i       = mw_pend ? mw_cur.mask : 8'h0;
    mem_wdata_i       = mw_pend ? mw_cur.data : 64'h0;
    mem_wsize_i       = mw_pend ? mw_cur.size : 4'h0;

    // A write stays in the way of MEM reads through its acknowledge cycle
    s_if_v = if_pend; s_if = if_cur;
    s_mr_v = mr_pend; s_mr = mr_cur;
    s_mw_v = mw_pend; s_mw = mw_cur;
    s_mw_blk = mw_pend || wack;
    r_prev = arb_raddr_valid_o;
    w_prev = arb_write_valid_o;
  endtask

  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while ((if_q.size() > 0 || mr_q.size() > 0 || mw_q.size() > 0 || if_pend || mr_pend || mw_pend)
           && n < budget) begin
      service();
      tick();
      n++;
    end
    chk({name, "_timeout"}, (n < budget), 1'b1);
  endtask

  vec_t vt[8];
  int   exp2[3];

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_clear();
    reset_dut();

    chk("rst_raddr_valid", arb_raddr_valid_o, 1'b0);
    chk("rst_write_valid", arb_write_valid_o, 1'b0);
    chk("rst_if_ready", if_rdata_ready_o, 1'b0);
    chk("rst_mem_ready", mem_rdata_ready_o, 1'b0);
    chk("rst_wr_ready", mem_wdata_ready_o, 1'b0);
    chk("rst_raddr", arb_read_addr_o, 64'h0);
    chk("rst_waddr", arb_write_addr_o, 64'h0);
    chk("rst_wdata", arb_wdata_o, 64'h0);
    chk("rst_if_rdata", if_rdata_o, 64'h0);

    // Grant decisions from idle: {if, mem_rd, mem_wr} -> {rd valid, rd addr, wr valid}
    vt[0] = '{0, 0, 0, 0, 64'h0, 0};
    vt[1] = '{1, 0, 0, 1, A_IF,  0};
    vt[2] = '{0, 1, 0, 1, A_MEM, 0};
    vt[3] = '{1, 1, 0, 1, A_IF,  0};
    vt[4] = '{0, 1, 1, 0, 64'h0, 1};
    vt[5] = '{1, 0, 1, 1, A_IF,  1};
    vt[6] = '{0, 0, 1, 0, 64'h0, 1};
    vt[7] = '{1, 1, 1, 1, A_IF,  1};
    for (int i = 0; i < 8; i++) begin
      reset_dut();
      if (vt[i].if_v) if_q.push_back(mk(A_IF, 8'hFF, 4'd3, 64'h0));
      if (vt[i].mr_v) mr_q.push_back(mk(A_MEM, 8'h0F, 4'd2, 64'h0));
      if (vt[i].mw_v) mw_q.push_back(mk(A_WR, 8'h0F, 4'd2, 64'hDEAD_BEEF));
      service();
      tick();
      chk($sformatf("vec%0d_rvalid", i), arb_raddr_valid_o, vt[i].exp_rv);
      chk($sformatf("vec%0d_wvalid", i), arb_write_valid_o, vt[i].exp_wv);
      if (vt[i].exp_rv) chk($sformatf("vec%0d_raddr", i), arb_read_addr_o, vt[i].exp_addr);
      drain($sformatf("vec%0d", i), 100);
    end

    // Exact latency: ready two cycles after valid rises
    reset_dut();
    if_raddr_valid_i = 1'b1; if_read_addr_i = A_IF; if_rmask_i = 8'hFF; if_rsize_i = 4'd3;
    tick();
    chk("lat_c1_valid", arb_raddr_valid_o, 1'b1);
    chk("lat_c1_addr", arb_read_addr_o, A_IF);
    tick();
    chk("lat_c2_valid", arb_raddr_valid_o, 1'b1);
    tick();
    chk("lat_c3_valid", arb_raddr_valid_o, 1'b1);
    arb_rdata_ready_i = 1'b1; arb_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    arb_rdata_ready_i = 1'b0; arb_rdata_i = 64'h0; if_raddr_valid_i = 1'b0;
    chk("lat_c4_valid", arb_raddr_valid_o, 1'b0);
    chk("lat_c4_if_ready", if_rdata_ready_o, 1'b1);
    chk("lat_c4_if_data", if_rdata_o, 64'h1122_3344_5566_7788);
    chk("lat_c4_mem_ready", mem_rdata_ready_o, 1'b0);
    tick();
    chk("lat_c5_if_ready", if_rdata_ready_o, 1'b0);
    chk("lat_c5_if_data", if_rdata_o, 64'h0);

    // IF and MEM together, IF re-requesting right after its response
    reset_dut();
    if_q.push_back(mk(A_IF, 8'hFF, 4'd3, 64'h0));
    if_q.push_back(mk(A_IF + 64'h40, 8'hFF, 4'd3, 64'h0));
    mr_q.push_back(mk(A_MEM, 8'hFF, 4'd3, 64'h0));
    drain("order", 100);
    if (RR) begin exp2[0] = 0; exp2[1] = 1; exp2[2] = 0; end
    else    begin exp2[0] = 0; exp2[1] = 0; exp2[2] = 1; end
    chk("order_count", gq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("order_%0d", i), (gq.size() > i) ? gq[i] : -1, exp2[i]);

    // MEM write and MEM read together: write finishes before the read is issued
    reset_dut();
    mw_q.push_back(mk(A_WR, 8'h0F, 4'd2, 64'hDEAD_BEEF));
    mr_q.push_back(mk(A_MEM, 8'hFF, 4'd3, 64'h0));
    drain("wr_first", 100);
    chk("wr_before_rd", (mrise_cyc > wack_cyc) && (wack_cyc >= 0), 1'b1);
    chk("wr_first_mem_done", mr_done, 1);
    chk("wr_first_wr_done", mw_done, 1);

    // Write issued while an IF read is outstanding downstream
    reset_dut();
    r_lat_fix = 6;
    if_q.push_back(mk(A_IF, 8'hFF, 4'd3, 64'h0));
    for (int i = 0; i < 3; i++) begin service(); tick(); end
    mw_q.push_back(mk(A_WR, 8'h0F, 4'd2, 64'hDEAD_BEEF));
    drain("overlap", 100);
    chk("overlap_both_valid", both_seen, 1'b1);
    chk("overlap_if_done", if_done, 1);
    chk("overlap_wr_done", mw_done, 1);

    // Reset mid-read, then a stray downstream ready
    reset_dut();
    if_raddr_valid_i = 1'b1; if_read_addr_i = A_IF; if_rmask_i = 8'hFF; if_rsize_i = 4'd3;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; if_raddr_valid_i = 1'b0;
    arb_rdata_ready_i = 1'b1; arb_rdata_i = 64'hFFFF_0000_FFFF_0000;
    chk("rstmid_rvalid", arb_raddr_valid_o, 1'b0);
    chk("rstmid_raddr", arb_read_addr_o, 64'h0);
    chk("rstmid_if_ready", if_rdata_ready_o, 1'b0);
    tick();
    arb_rdata_ready_i = 1'b0; arb_rdata_i = 64'h0;
    chk("stray_if_ready", if_rdata_ready_o, 1'b0);
    chk("stray_rvalid", arb_raddr_valid_o, 1'b0);
    model_clear();
    if_q.push_back(mk(A_IF + 64'h80, 8'hF0, 4'd1, 64'h0));
    drain("after_rst", 50);
    chk("after_rst_done", if_done, 1);

    // Random concurrent traffic against the rule model
    reset_dut();
    begin
      int if_iss, mr_iss, mw_iss;
      if_iss = 0; mr_iss = 0; mw_iss = 0;
      for (int c = 0; c < 3000; c++) begin
        if (if_q.size() == 0 && $urandom_range(0, 3) == 0) begin if_q.push_back(mk_rand(0)); if_iss++; end
        if (mr_q.size() == 0 && $urandom_range(0, 3) == 0) begin mr_q.push_back(mk_rand(1)); mr_iss++; end
        if (mw_q.size() == 0 && $urandom_range(0, 5) == 0) begin mw_q.push_back(mk_rand(2)); mw_iss++; end
        service();
        tick();
      end
      drain("rand", 500);
      chk("rand_if_done", if_done, if_iss);
      chk("rand_mem_done", mr_done, mr_iss);
      chk("rand_wr_done", mw_done, mw_iss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
